seq_decoder: RTL and testbench

SEQ_DECODER -- requirements
Module: seq_decoder

---
 rtl/seq_decoder_pkg.sv | 16 +
 rtl/seq_decoder_dec_core.sv | 36 +++
 rtl/seq_decoder.sv | 110 +++++++++++
 tb/tb_seq_decoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_decoder_pkg.sv
// Shared types for the sequenced decoder: request mode encodings and FSM states.
package seq_decoder_pkg;

   typedef enum logic [1:0] {
      MODE_ONEHOT = 2'b00,
      MODE_THERM  = 2'b01,
      MODE_SCAN   = 2'b10,
      MODE_BLANK  = 2'b11
   } mode_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

endpackage

// File: rtl/seq_decoder_dec_core.sv
// Pure combinational select-to-pattern decoder. Scan mode decodes as one-hot,
// because every step of a scan displays a single set bit.
module dec_core
   import seq_decoder_pkg::*;
#(
   parameter  int SEL_W = 3,
   localparam int OUT_W = 2**SEL_W
) (
   input  logic [SEL_W-1:0] sel,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] pattern
);

   logic [OUT_W-1:0] onehot_pat;
   logic [OUT_W-1:0] therm_pat;

   // Build both candidate patterns bit by bit.
   generate
      for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
         assign onehot_pat[gi] = (sel == SEL_W'(gi));
         assign therm_pat[gi]  = (SEL_W'(gi) <= sel);
      end
   endgenerate

   // Pick the pattern for the requested mode; blank yields all-zero.
   always_comb begin
      pattern = '0;
      case (mode)
         MODE_ONEHOT: pattern = onehot_pat;
         MODE_THERM:  pattern = therm_pat;
         MODE_SCAN:   pattern = onehot_pat;
         default:     pattern = '0;
      endcase
   end

endmodule

// File: rtl/seq_decoder.sv
// Sequenced decoder: single-cycle one-hot/thermometer/blank results, or a
// multi-cycle scan that walks a single bit from position 0 up to the target.
module seq_decoder
   import seq_decoder_pkg::*;
#(
   parameter  int SEL_W = 3,
   localparam int OUT_W = 2**SEL_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEL_W-1:0] sel,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] y,
   output logic             out_valid,
   output logic             busy
);

   state_t           state_reg, state_next;
   logic [SEL_W-1:0] step_reg, step_next;
   logic [SEL_W-1:0] target_reg, target_next;
   logic [OUT_W-1:0] y_reg, y_next;
   logic             out_valid_reg, out_valid_next;

   logic [SEL_W-1:0] core_sel;
   logic [1:0]       core_mode;
   logic [OUT_W-1:0] core_pattern;
   logic [SEL_W-1:0] step_inc;

   assign step_inc  = step_reg + 1'b1;
   assign in_ready  = (state_reg == ST_IDLE) & ~clr & rst_n;
   assign busy      = (state_reg == ST_SCAN);
   assign y         = y_reg;
   assign out_valid = out_valid_reg;

   dec_core #(.SEL_W(SEL_W)) u_dec_core (
      .sel     (core_sel),
      .mode    (core_mode),
      .pattern (core_pattern)
   );

   // State, step counter, latched target and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         step_reg      <= '0;
         target_reg    <= '0;
         y_reg         <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         step_reg      <= step_next;
         target_reg    <= target_next;
         y_reg         <= y_next;
         out_valid_reg <= out_valid_next;
      end
   end

   // Next-state logic; a scan always starts by displaying bit 0, and while
   // scanning the core is driven from the counter so live sel/mode are ignored.
   always_comb begin
      state_next     = state_reg;
      step_next      = step_reg;
      target_next    = target_reg;
      y_next         = y_reg;
      out_valid_next = 1'b0;
      core_sel       = (mode == MODE_SCAN) ? '0 : sel;
      core_mode      = mode;

      if (clr) begin
         state_next  = ST_IDLE;
         step_next   = '0;
         target_next = '0;
         y_next      = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (in_valid) begin
                  y_next = core_pattern;
                  if ((mode == MODE_SCAN) && (sel != '0)) begin
                     state_next  = ST_SCAN;
                     target_next = sel;
                     step_next   = '0;
                  end else begin
                     out_valid_next = 1'b1;
                  end
               end
            end
            ST_SCAN: begin
               core_sel  = step_inc;
               core_mode = MODE_ONEHOT;
               y_next    = core_pattern;
               step_next = step_inc;
               if (step_inc == target_reg) begin
                  state_next     = ST_IDLE;
                  step_next      = '0;
                  out_valid_next = 1'b1;
               end
            end
            default: begin
               state_next = ST_IDLE;
               step_next  = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_decoder.sv
// Directed bench for seq_decoder (SEL_W = 3): one task per scenario.
module tb_seq_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] sel;
   logic [1:0] mode;
   logic [7:0] y;
   logic       out_valid;
   logic       busy;

   int checks = 0;
   int errors = 0;

   seq_decoder #(.SEL_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .mode      (mode),
      .y         (y),
      .out_valid (out_valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then settle at the falling edge for sampling/driving.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; sel = '0; mode = 2'b00;
      #12;
      checks++;
      if ({y, out_valid, busy, in_ready} !== 11'b0) begin
         errors++;
         $display("FAIL reset: y=%h ov=%b busy=%b rdy=%b, want all 0", y, out_valid, busy, in_ready);
      end else $display("reset: outputs zero");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
      end else $display("reset release: in_ready=1");
      @(negedge clk);
   endtask

   task automatic test_onehot();
      mode = 2'b00; sel = 3'd5; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (y !== 8'h20 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL onehot5: y=%h ov=%b want y=20 ov=1", y, out_valid);
      end else $display("onehot sel=5: y=%h ov=%b", y, out_valid);
      step();
      checks++;
      if (y !== 8'h20 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL onehot_hold: y=%h ov=%b want y=20 ov=0", y, out_valid);
      end else $display("onehot hold: y=%h ov=%b", y, out_valid);
   endtask

   task automatic test_therm_blank();
      mode = 2'b01; sel = 3'd3; in_valid = 1'b1;
      step();
      checks++;
      if (y !== 8'h0F || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL therm3: y=%h ov=%b want y=0f ov=1", y, out_valid);
      end else $display("therm sel=3: y=%h ov=%b", y, out_valid);
      mode = 2'b11; sel = 3'd6;
      step();
      in_valid = 1'b0;
      checks++;
      if (y !== 8'h00 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL blank: y=%h ov=%b want y=00 ov=1", y, out_valid);
      end else $display("blank: y=%h ov=%b", y, out_valid);
      mode = 2'b01; sel = 3'd7; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (y !== 8'hFF || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL therm7: y=%h ov=%b want y=ff ov=1", y, out_valid);
      end else $display("therm sel=7: y=%h ov=%b", y, out_valid);
      step();
   endtask

   // Full-range scan; sel/mode are scrambled after acceptance to confirm they are ignored.
   task automatic test_scan_full();
      logic [7:0] exp_y;
      mode = 2'b10; sel = 3'd7; in_valid = 1'b1;
      step();
      in_valid = 1'b0; sel = 3'd2; mode = 2'b01;
      for (int i = 0; i < 8; i++) begin
         exp_y = 8'h01 << i;
         checks++;
         if (y !== exp_y || out_valid !== (i == 7) || busy !== (i < 7) || in_ready !== (i == 7)) begin
            errors++;
            $display("FAIL scan7_step%0d: y=%h ov=%b busy=%b rdy=%b want y=%h ov=%b busy=%b rdy=%b",
                     i, y, out_valid, busy, in_ready, exp_y, (i == 7), (i < 7), (i == 7));
         end else $display("scan7 step %0d: y=%h ov=%b busy=%b rdy=%b", i, y, out_valid, busy, in_ready);
         if (i < 7) step();
      end
      step();
      checks++;
      if (y !== 8'h80 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL scan7_after: y=%h ov=%b busy=%b want y=80 ov=0 busy=0", y, out_valid, busy);
      end else $display("scan7 after: y=%h held", y);
   endtask

   task automatic test_scan_clr();
      mode = 2'b10; sel = 3'd6; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      checks++;
      if (y !== 8'h02 || busy !== 1'b1) begin
         errors++;
         $display("FAIL scan6_step1: y=%h busy=%b want y=02 busy=1", y, busy);
      end else $display("scan6 step 1: y=%h busy=%b", y, busy);
      step();
      clr = 1'b1; in_valid = 1'b1; mode = 2'b00; sel = 3'd3;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL clr_ready: in_ready=%b want 0", in_ready);
      end else $display("clr asserted: in_ready=0");
      step();
      clr = 1'b0; in_valid = 1'b0;
      #1;
      checks++;
      if (y !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL clr_abort: y=%h ov=%b busy=%b rdy=%b want y=00 ov=0 busy=0 rdy=1",
                  y, out_valid, busy, in_ready);
      end else $display("clr abort: y=%h ov=%b busy=%b rdy=%b", y, out_valid, busy, in_ready);
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (y !== 8'h00 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_quiet%0d: y=%h ov=%b want y=00 ov=0", i, y, out_valid);
         end else $display("post-clr cycle %0d: quiet", i);
      end
   endtask

   task automatic test_scan_sel0();
      mode = 2'b10; sel = 3'd0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (y !== 8'h01 || out_valid !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL scan_sel0: y=%h ov=%b busy=%b rdy=%b want y=01 ov=1 busy=0 rdy=1",
                  y, out_valid, busy, in_ready);
      end else $display("scan sel=0: y=%h ov=%b busy=%b", y, out_valid, busy);
      step();
   endtask

   // Asynchronous reset mid-scan, then back-to-back one-hot requests sel=0..7.
   task automatic test_async_reset_back_to_back();
      logic [7:0] exp_y;
      mode = 2'b10; sel = 3'd7; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (y !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: y=%h busy=%b rdy=%b ov=%b want all 0", y, busy, in_ready, out_valid);
      end else $display("async reset mid-scan: outputs zero");
      @(negedge clk);
      rst_n = 1'b1; mode = 2'b00; in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sel = 3'(i);
         exp_y = 8'h01 << i;
         step();
         checks++;
         if (y !== exp_y || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_%0d: y=%h ov=%b rdy=%b want y=%h ov=1 rdy=1", i, y, out_valid, in_ready, exp_y);
         end else $display("back-to-back sel=%0d: y=%h ov=%b", i, y, out_valid);
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (y !== 8'h80 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: y=%h ov=%b want y=80 ov=0", y, out_valid);
      end else $display("back-to-back end: y=%h held", y);
   endtask

   initial begin
      test_reset();
      test_onehot();
      test_therm_blank();
      test_scan_full();
      test_scan_clr();
      test_scan_sel0();
      test_async_reset_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
